// File: rtl/output_unloader_bp.sv
// Decoder output unloader: reads UNLOADCOUNT wide hard-decision words from memory
// under a credit limit, buffers them and streams kl HDDW-bit beats per word.
module output_unloader_bp #(
    parameter int KB           = 14,
    parameter int HDDW         = 32,
    parameter int ADDRESSWIDTH = 5,
    parameter int UNLOADCOUNT  = 17,
    parameter int RDLAT        = 2,
    parameter int FIFODEPTH    = 4,
    parameter int KBW          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    unload_start,
    input  logic [KBW-1:0]          kb_active,
    output logic                    unload_en,
    output logic [ADDRESSWIDTH-1:0] unload_addr,
    input  logic [KB*HDDW-1:0]      wrdin_vec,
    output logic [HDDW-1:0]         hd_out,
    output logic                    hd_valid,
    input  logic                    hd_ready,
    output logic                    hd_last,
    output logic                    busy,
    output logic                    done
);

    localparam int PTRW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam int ISW  = ADDRESSWIDTH + 1;
    localparam int CRW  = $clog2(FIFODEPTH + RDLAT + 1);
    localparam int WW   = KB * HDDW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNLOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [ISW-1:0]  issued_q, issued_d;
    logic [ISW-1:0]  popped_q, popped_d;
    logic [KBW-1:0]  kl_q, kl_d;
    logic [KBW-1:0]  beat_q, beat_d;
    logic [RDLAT-1:0] pipe_q, pipe_d;
    logic [WW-1:0]   mem_q [FIFODEPTH];
    logic [WW-1:0]   mem_d [FIFODEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    logic [CRW-1:0]  credit_used;
    logic            fifo_push;
    logic            fifo_pop;
    logic            xfer;
    logic            last_beat;

    // Credits cover both buffered words and reads whose data is still in flight.
    always_comb begin
        credit_used = CRW'(count_q);
        for (int i = 0; i < RDLAT; i++) begin
            credit_used = credit_used + CRW'(pipe_q[i]);
        end
    end

    assign unload_en   = (state_q == S_UNLOAD) &&
                         (issued_q < ISW'(UNLOADCOUNT)) &&
                         (credit_used < CRW'(FIFODEPTH));
    assign unload_addr = issued_q[ADDRESSWIDTH-1:0];

    // Stream handshake: a beat moves when hd_valid & hd_ready; while hd_valid is
    // high and hd_ready low, hd_out/hd_last/hd_valid hold because nothing pops.
    assign hd_valid  = (count_q != '0);
    assign xfer      = hd_valid && hd_ready;
    assign last_beat = (beat_q == kl_q - KBW'(1));
    assign fifo_pop  = xfer && last_beat;
    assign fifo_push = pipe_q[RDLAT-1];
    assign hd_out    = hd_valid ? mem_q[rd_ptr_q][int'(beat_q)*HDDW +: HDDW] : '0;
    assign hd_last   = hd_valid && last_beat && (popped_q == ISW'(UNLOADCOUNT - 1));

    assign busy = (state_q == S_UNLOAD) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        popped_d = popped_q;
        kl_d     = kl_q;
        beat_d   = beat_q;

        if (unload_en) issued_d = issued_q + ISW'(1);
        if (xfer) beat_d = last_beat ? '0 : beat_q + KBW'(1);
        if (fifo_pop) popped_d = popped_q + ISW'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d  = S_IDLE;
                issued_d = '0;
                if (unload_start) begin
                    state_d  = S_UNLOAD;
                    popped_d = '0;
                    beat_d   = '0;
                    kl_d     = (kb_active == '0 || kb_active > KBW'(KB)) ? KBW'(KB) : kb_active;
                end
            end
            S_UNLOAD: begin
                if (unload_en && issued_q == ISW'(UNLOADCOUNT - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The final beat only exists once every read has landed and drained.
                if (xfer && hd_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = unload_en;
        for (int i = 1; i < RDLAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = wrdin_vec;
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (fifo_pop) rd_ptr_d = rd_ptr_q + PTRW'(1);
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            popped_q <= '0;
            kl_q     <= KBW'(KB);
            beat_q   <= '0;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            kl_q     <= kl_d;
            beat_q   <= beat_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && count_q == CNTW'(FIFODEPTH)));

endmodule

// File: tb/tb_output_unloader_bp.sv
// Bench for output_unloader_bp: memory model with read latency, randomized sink
// readiness, and a scoreboard of expected beats built from the frame contents.
module tb_output_unloader_bp;
  localparam int KB = 14;
  localparam int HDDW = 32;
  localparam int AW = 5;
  localparam int UC = 17;
  localparam int RDLAT = 2;
  localparam int FIFODEPTH = 4;
  localparam int KBW = 4;
  localparam int WW = KB * HDDW;

  logic clk, rst, unload_start, unload_en, hd_valid, hd_ready, hd_last, busy, done;
  logic [KBW-1:0] kb_active;
  logic [AW-1:0] unload_addr;
  logic [WW-1:0] wrdin_vec;
  logic [HDDW-1:0] hd_out;

  output_unloader_bp #(
    .KB(KB), .HDDW(HDDW), .ADDRESSWIDTH(AW), .UNLOADCOUNT(UC),
    .RDLAT(RDLAT), .FIFODEPTH(FIFODEPTH), .KBW(KBW)
  ) dut (
    .clk(clk), .rst(rst), .unload_start(unload_start), .kb_active(kb_active),
    .unload_en(unload_en), .unload_addr(unload_addr), .wrdin_vec(wrdin_vec),
    .hd_out(hd_out), .hd_valid(hd_valid), .hd_ready(hd_ready), .hd_last(hd_last),
    .busy(busy), .done(done)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared state
  int n_checks = 0;
  int n_fail = 0;
  logic [HDDW:0] exp_q[$];
  logic [WW-1:0] mem_words [32];
  int start_cyc = 0;
  int ready_mode = 0;
  int hold_cycles = 100;
  int cur_kl = KB;
  int reads_issued = 0;
  int words_popped = 0;
  int beats_seen = 0;
  int beat_in_word = 0;
  int done_seen = 0;
  int first_en_rel = -1;
  int first_valid_rel = -1;
  int last_beat_rel = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_unload_en"}, unload_en, 0);
    check({tag, "_unload_addr"}, unload_addr, 0);
    check({tag, "_hd_valid"}, hd_valid, 0);
    check({tag, "_hd_last"}, hd_last, 0);
    check({tag, "_hd_out"}, hd_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // memory model: data for a read appears RDLAT cycles after unload_en
  initial begin
    logic [AW:0] hist_q[$];
    logic [AW:0] h;
    wrdin_vec = '0;
    forever begin
      @(negedge clk);
      hist_q.push_back({unload_en, unload_addr});
      if (hist_q.size() > RDLAT) begin
        h = hist_q.pop_front();
        if (h[AW]) wrdin_vec = mem_words[h[AW-1:0]];
        else wrdin_vec = {KB{$urandom()}};
      end
    end
  end

  // sink readiness driver
  initial begin
    int rel_r;
    hd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rel_r = cyc - start_cyc;
      case (ready_mode)
        0: hd_ready = 1'b1;
        1: hd_ready = (rel_r % 4 == 0);
        2: hd_ready = ($urandom_range(0, 3) != 0);
        default: hd_ready = (rel_r >= hold_cycles);
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic [HDDW:0] e;
    int rel;
    bit prev_stall, last_xfer_prev;
    logic [HDDW-1:0] prev_out;
    logic prev_last;
    prev_stall = 0; last_xfer_prev = 0; prev_out = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        last_xfer_prev = 0;
      end else begin
        rel = cyc - start_cyc;
        if (unload_en) begin
          check("rd_addr", unload_addr, reads_issued);
          check("rd_credit", (reads_issued - words_popped) < FIFODEPTH, 1);
          check("rd_count", reads_issued < UC, 1);
          if (first_en_rel < 0) first_en_rel = rel;
          reads_issued++;
        end
        if (hd_valid && first_valid_rel < 0) first_valid_rel = rel;
        if (prev_stall) begin
          check("stall_valid", hd_valid, 1);
          check("stall_out", hd_out, prev_out);
          check("stall_last", hd_last, prev_last);
        end
        if (done) begin
          check("done_busy", busy, 0);
          check("done_after_last", last_xfer_prev, 1);
          done_seen++;
        end else if (last_xfer_prev) begin
          check("done_pulse", done, 1);
        end
        last_xfer_prev = 0;
        if (hd_valid && hd_ready) begin
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_data", hd_out, e[HDDW-1:0]);
            check("beat_last", hd_last, e[HDDW]);
            last_xfer_prev = e[HDDW];
          end
          beats_seen++;
          beat_in_word++;
          if (beat_in_word == cur_kl) begin
            words_popped++;
            beat_in_word = 0;
          end
          last_beat_rel = rel;
        end
        prev_stall = hd_valid && !hd_ready;
        prev_out = hd_out;
        prev_last = hd_last;
      end
    end
  end

  task automatic run_frame(input int kb, input int mode, input bit pattern,
                           input bit restart, input bit abort);
    int kl, rel, done_before;
    bit ok;
    kl = (kb == 0 || kb > KB) ? KB : kb;
    for (int n = 0; n < UC; n++)
      for (int b = 0; b < KB; b++)
        mem_words[n][b*HDDW +: HDDW] = pattern ? 32'(n * 16 + b) : $urandom();
    exp_q.delete();
    reads_issued = 0; words_popped = 0; beats_seen = 0; beat_in_word = 0;
    cur_kl = kl; first_en_rel = -1; first_valid_rel = -1; last_beat_rel = -1;
    for (int n = 0; n < UC; n++)
      for (int b = 0; b < kl; b++)
        exp_q.push_back({(n == UC - 1 && b == kl - 1), mem_words[n][b*HDDW +: HDDW]});
    ready_mode = mode;
    done_before = done_seen;

    @(posedge clk); #1;
    kb_active = KBW'(kb);
    unload_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    check("busy_at_start", busy, 0);
    @(posedge clk); #1;
    unload_start = 1'b0;
    @(negedge clk); #1;
    check("busy_after_start", busy, 1);

    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(posedge clk); #1;
      rel = cyc - start_cyc;
      unload_start = restart && (rel == 10 || rel == 50);
      if (unload_start) kb_active = KBW'(3);
      if (abort && rel == 20) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_idle("abort");
        exp_q.delete();
        repeat (30) @(posedge clk);
        check("abort_no_done", done_seen, done_before);
        return;
      end
      if (mode == 3 && rel == 99) begin
        @(negedge clk); #1;
        check("hold_reads", reads_issued, FIFODEPTH);
        check("hold_en", unload_en, 0);
      end
      ok = (done_seen != done_before);
    end
    check("frame_done", ok, 1);
    repeat (6) @(posedge clk);
    check("beats", beats_seen, UC * kl);
    check("exp_empty", exp_q.size(), 0);
    check("done_count", done_seen - done_before, 1);
    check("first_en_cycle", first_en_rel, 1);
    check("first_valid_cycle", first_valid_rel, 4);
    if (mode == 0) check("last_beat_cycle", last_beat_rel, UC * kl + 3);
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    unload_start = 1'b0;
    kb_active = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    check_idle("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_idle("after_reset");

    run_frame(14, 0, 1, 0, 0);
    run_frame(3, 0, 1, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    run_frame(15, 0, 0, 0, 0);
    run_frame(14, 1, 1, 0, 0);
    hold_cycles = 100;
    run_frame(14, 3, 1, 0, 0);
    run_frame(14, 0, 1, 1, 0);
    run_frame(14, 0, 1, 0, 1);
    run_frame(14, 0, 1, 0, 0);
    for (int f = 0; f < 4; f++) run_frame($urandom_range(0, 15), 2, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
